// File: rtl/wfg_record_spi_pkg.sv
// wfg_record_spi_pkg
//   Shared definitions for the SPI record block: register offsets,
//   control/config register layouts and the receive FSM state enum.
package wfg_record_spi_pkg;

   localparam logic [3:0] REG_CTRL   = 4'h0;
   localparam logic [3:0] REG_CFG    = 4'h4;
   localparam logic [3:0] REG_STATUS = 4'h8;

   // CTRL: bit0 en, bit1 cpol, bit2 cpha, bit3 lsb_first
   typedef struct packed {
      logic lsb_first;
      logic cpha;
      logic cpol;
      logic en;
   } ctrl_t;

   // CFG: word length minus one (1..32 bit words)
   typedef struct packed {
      logic [4:0] wlen_m1;
   } cfg_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/wfg_record_spi_wishbone_reg.sv
// wfg_record_spi_wishbone_reg
//   Wishbone classic slave holding the CTRL/CFG registers and presenting
//   STATUS. One-cycle ack, never back-to-back; writes land with the ack.
// Ports:
//   wb_clk_i, wb_rst_ni   clock, async active-low reset
//   stb/cyc/we/adr/dat_i  Wishbone request (adr is the decoded nibble)
//   ack/dat_o             Wishbone response (dat_o is zero outside a read ack)
//   ovf, fifo_level       live status from the receive path
//   ctrl, cfg             register contents
//   ovf_clr               one-cycle pulse on write-1 to STATUS[0]
module wfg_record_spi_wishbone_reg
   import wfg_record_spi_pkg::*;
#(
   parameter int BUSW = 32
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_ni,
   input  logic            stb,
   input  logic            cyc,
   input  logic            we,
   input  logic [3:0]      adr,
   input  logic [BUSW-1:0] dat_i,
   output logic            ack,
   output logic [BUSW-1:0] dat_o,
   input  logic            ovf,
   input  logic [4:0]      fifo_level,
   output ctrl_t           ctrl,
   output cfg_t            cfg,
   output logic            ovf_clr
);

   logic acc;
   logic unused_dat;

   // the ack-low term is what forbids back-to-back acks
   assign acc        = stb & cyc & ~ack;
   assign unused_dat = &{1'b0, dat_i[BUSW-1:5]};

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         ack     <= 1'b0;
         dat_o   <= '0;
         ctrl    <= '0;
         cfg     <= '0;
         ovf_clr <= 1'b0;
      end else begin
         ack     <= acc;
         ovf_clr <= 1'b0;
         dat_o   <= '0;
         if (acc && we) begin
            case (adr)
               REG_CTRL:   ctrl    <= ctrl_t'(dat_i[3:0]);
               REG_CFG:    cfg     <= cfg_t'(dat_i[4:0]);
               REG_STATUS: ovf_clr <= dat_i[0];
               default:    ;
            endcase
         end else if (acc) begin
            case (adr)
               REG_CTRL:   dat_o <= {{(BUSW-4){1'b0}}, ctrl};
               REG_CFG:    dat_o <= {{(BUSW-5){1'b0}}, cfg};
               REG_STATUS: dat_o <= {{(BUSW-9){1'b0}}, fifo_level, 3'b000, ovf};
               default:    dat_o <= '0;
            endcase
         end
      end
   end

endmodule

// File: rtl/wfg_record_spi_top.sv
// wfg_record_spi_top
//   SPI receiver (slave side, sampling only) feeding an AXI-Stream word FIFO,
//   configured over Wishbone. SPI pins are asynchronous and are brought in
//   through 2-flop synchronizers; sclk must be at most wb_clk_i/4.
// Ports:
//   wb_clk_i, wb_rst_ni             clock, async active-low reset
//   wbs_*                           Wishbone classic slave
//   wfg_record_spi_{sclk,cs_n,sdi}  asynchronous SPI inputs
//   wfg_axis_tready_i/tvalid_o/tdata_o  received word stream (right-aligned)
module wfg_record_spi_top
   import wfg_record_spi_pkg::*;
#(
   parameter int BUSW       = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_ni,
   input  logic            wbs_stb_i,
   input  logic            wbs_cyc_i,
   input  logic            wbs_we_i,
   input  logic [3:0]      wbs_sel_i,
   input  logic [BUSW-1:0] wbs_adr_i,
   input  logic [BUSW-1:0] wbs_dat_i,
   output logic            wbs_ack_o,
   output logic [BUSW-1:0] wbs_dat_o,
   input  logic            wfg_record_spi_sclk_i,
   input  logic            wfg_record_spi_cs_ni,
   input  logic            wfg_record_spi_sdi_i,
   input  logic            wfg_axis_tready_i,
   output logic            wfg_axis_tvalid_o,
   output logic [31:0]     wfg_axis_tdata_o
);

   localparam int AW = $clog2(FIFO_DEPTH);

   ctrl_t  ctrl, sh_ctrl;
   cfg_t   cfg, sh_cfg;
   logic   ovf, ovf_clr;
   logic   unused_bits;

   logic [1:0] sclk_sync, cs_sync, sdi_sync;
   logic       sclk_d, cs_d;
   logic       sclk_rise, sclk_fall, cs_fall, cs_rise, sample_edge;

   state_t      state, state_nxt;
   logic        start, shift_en;
   logic [4:0]  cnt;
   logic [31:0] sreg, shifted, word_q;
   logic        push_q;

   logic [FIFO_DEPTH-1:0][31:0] mem;
   logic [AW:0] wr_ptr, rd_ptr, level;
   logic        empty, full, pop, push_ok;

   assign unused_bits = &{1'b0, wbs_sel_i, wbs_adr_i[BUSW-1:4]};

   wfg_record_spi_wishbone_reg #(.BUSW(BUSW)) u_reg (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_ni  (wb_rst_ni),
      .stb        (wbs_stb_i),
      .cyc        (wbs_cyc_i),
      .we         (wbs_we_i),
      .adr        (wbs_adr_i[3:0]),
      .dat_i      (wbs_dat_i),
      .ack        (wbs_ack_o),
      .dat_o      (wbs_dat_o),
      .ovf        (ovf),
      .fifo_level (5'(level)),
      .ctrl       (ctrl),
      .cfg        (cfg),
      .ovf_clr    (ovf_clr)
   );

   // synchronizers; the extra *_d flop gives edge detection on the
   // synchronized value, so sdi_sync[1] is aligned with the edge pulse
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         sclk_sync <= 2'b00;
         cs_sync   <= 2'b11;
         sdi_sync  <= 2'b00;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[0], wfg_record_spi_sclk_i};
         cs_sync   <= {cs_sync[0], wfg_record_spi_cs_ni};
         sdi_sync  <= {sdi_sync[0], wfg_record_spi_sdi_i};
         sclk_d    <= sclk_sync[1];
         cs_d      <= cs_sync[1];
      end
   end

   assign sclk_rise = sclk_sync[1] & ~sclk_d;
   assign sclk_fall = ~sclk_sync[1] & sclk_d;
   assign cs_fall   = ~cs_sync[1] & cs_d;
   assign cs_rise   = cs_sync[1] & ~cs_d;
   // modes 0 and 3 sample on rising sclk, modes 1 and 2 on falling
   assign sample_edge = (sh_ctrl.cpol ^ sh_ctrl.cpha) ? sclk_fall : sclk_rise;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) state <= ST_IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cs_fall && ctrl.en) begin
               state_nxt = ST_SHIFT;
               start     = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (cs_rise || !ctrl.en) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      // a frame ending this cycle takes no further bits
      shift_en = (state == ST_SHIFT) && (state_nxt == ST_SHIFT) && sample_edge;
   end

   // LSB-first inserts at bit wlen-1 and shifts right so the first bit
   // lands in bit 0; MSB-first shifts left from a cleared register. Both
   // leave the bits above wlen zero.
   always_comb begin
      if (sh_ctrl.lsb_first)
         shifted = (sreg >> 1) | (32'(sdi_sync[1]) << sh_cfg.wlen_m1);
      else
         shifted = {sreg[30:0], sdi_sync[1]};
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         sh_ctrl <= '0;
         sh_cfg  <= '0;
         cnt     <= '0;
         sreg    <= '0;
         word_q  <= '0;
         push_q  <= 1'b0;
      end else begin
         push_q <= 1'b0;
         if (start) begin
            sh_ctrl <= ctrl;
            sh_cfg  <= cfg;
         end
         if (shift_en) begin
            if (cnt == sh_cfg.wlen_m1) begin
               word_q <= shifted;
               push_q <= 1'b1;
               cnt    <= '0;
               sreg   <= '0;
            end else begin
               sreg <= shifted;
               cnt  <= cnt + 5'd1;
            end
         end else if (state_nxt == ST_IDLE) begin
            cnt  <= '0;
            sreg <= '0;
         end
      end
   end

   // word FIFO; pointers carry one extra bit so full and empty differ
   assign level   = wr_ptr - rd_ptr;
   assign empty   = (level == '0);
   assign full    = (level == (AW+1)'(FIFO_DEPTH));
   assign pop     = ~empty & wfg_axis_tready_i;
   assign push_ok = push_q & (~full | pop);

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= word_q;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         // a new overflow wins over a clear in the same cycle
         if (push_q && full && !pop) ovf <= 1'b1;
         else if (ovf_clr)           ovf <= 1'b0;
      end
   end

   assign wfg_axis_tvalid_o = ~empty;
   assign wfg_axis_tdata_o  = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_wfg_record_spi_top.sv
module tb_wfg_record_spi_top;

   localparam int BUSW  = 32;
   localparam int DEPTH = 4;
   localparam int H     = 4;   // sclk half period in wb clocks

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            stb = 1'b0, cyc = 1'b0, we = 1'b0;
   logic [BUSW-1:0] adr = '0, wdat = '0;
   logic            ack;
   logic [BUSW-1:0] rdat;
   logic            sclk = 1'b0, cs_n = 1'b1, sdi = 1'b0;
   logic            tready = 1'b0;
   logic            tvalid;
   logic [31:0]     tdata;

   int          n_chk = 0, n_fail = 0;
   logic [31:0] exp_q[$];
   logic        m_ovf = 1'b0;
   int          rdy_mode = 2;   // 0 hold low, 1 random, 2 always high

   always #5 clk = ~clk;

   wfg_record_spi_top #(.BUSW(BUSW), .FIFO_DEPTH(DEPTH)) dut (
      .wb_clk_i              (clk),
      .wb_rst_ni             (rst_n),
      .wbs_stb_i             (stb),
      .wbs_cyc_i             (cyc),
      .wbs_we_i              (we),
      .wbs_sel_i             (4'hF),
      .wbs_adr_i             (adr),
      .wbs_dat_i             (wdat),
      .wbs_ack_o             (ack),
      .wbs_dat_o             (rdat),
      .wfg_record_spi_sclk_i (sclk),
      .wfg_record_spi_cs_ni  (cs_n),
      .wfg_record_spi_sdi_i  (sdi),
      .wfg_axis_tready_i     (tready),
      .wfg_axis_tvalid_o     (tvalid),
      .wfg_axis_tdata_o      (tdata)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [31:0] exp_status();
      return {23'b0, 5'(exp_q.size()), 3'b000, m_ovf};
   endfunction

   // consumer: picks tready each cycle and checks every word taken
   initial begin
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0:       tready = 1'b0;
            1:       tready = 1'($urandom_range(0, 1));
            default: tready = 1'b1;
         endcase
         if (rst_n && tvalid && tready) begin
            if (exp_q.size() == 0) chk("spurious_valid", {31'b0, tvalid}, 32'h0);
            else                   chk("axis_word", tdata, exp_q.pop_front());
         end
      end
   end

   task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
      int t = 0;
      @(negedge clk);
      adr = {28'b0, a}; wdat = d; we = 1'b1; stb = 1'b1; cyc = 1'b1;
      do begin @(negedge clk); t++; end while (!ack && t < 10);
      if (!ack) chk("wb_wr_timeout", {31'b0, ack}, 32'h1);
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
   endtask

   task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
      int t = 0;
      @(negedge clk);
      adr = {28'b0, a}; we = 1'b0; stb = 1'b1; cyc = 1'b1;
      do begin @(negedge clk); t++; end while (!ack && t < 10);
      if (!ack) chk("wb_rd_timeout", {31'b0, ack}, 32'h1);
      d = rdat;
      stb = 1'b0; cyc = 1'b0;
      @(negedge clk);
      chk("ack_one_cycle", {31'b0, ack}, 32'h0);
   endtask

   task automatic reg_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
      logic [31:0] r;
      wb_read(a, r);
      chk(tag, r, exp);
   endtask

   // reference: a word completes once wl bits have reached their sample edge
   task automatic model_push(input logic [31:0] d, input int wl);
      logic [31:0] m;
      m = (wl == 32) ? 32'hFFFF_FFFF : ((32'd1 << wl) - 32'd1);
      if (exp_q.size() >= DEPTH) m_ovf = 1'b1;
      else                       exp_q.push_back(d & m);
   endtask

   task automatic spi_bits(input logic [31:0] d, input int wl, input int n, input logic [3:0] mode);
      logic cpol, cpha, b;
      cpol = mode[1]; cpha = mode[2];
      for (int i = 0; i < n; i++) begin
         b = mode[3] ? d[i] : d[wl-1-i];
         if (!cpha) begin
            sdi = b; wait_clk(H);
            sclk = ~cpol;
            if (i == wl-1) model_push(d, wl);
            wait_clk(H);
            sclk = cpol;
         end else begin
            sclk = ~cpol; sdi = b; wait_clk(H);
            sclk = cpol;
            if (i == wl-1) model_push(d, wl);
            wait_clk(H);
         end
      end
   endtask

   task automatic spi_frame(input logic [31:0] d, input int wl, input int n, input logic [3:0] mode);
      sclk = mode[1]; wait_clk(4);
      cs_n = 1'b0;    wait_clk(4);
      spi_bits(d, wl, n, mode);
      wait_clk(H);
      cs_n = 1'b1;    wait_clk(6);
   endtask

   task automatic wait_drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 3000) begin @(negedge clk); t++; end
      chk("drain", 32'(exp_q.size()), 32'h0);
      wait_clk(3);
      chk("fifo_empty", {31'b0, tvalid}, 32'h0);
   endtask

   initial begin
      logic [31:0] d, m;
      int wl;

      wait_clk(3);
      chk("rst_tvalid", {31'b0, tvalid}, 32'h0);
      chk("rst_tdata",  tdata, 32'h0);
      chk("rst_ack",    {31'b0, ack}, 32'h0);
      chk("rst_dat",    rdat, 32'h0);
      rst_n = 1'b1;
      wait_clk(2);

      // register access
      wb_write(4'h0, 32'hF);
      reg_chk("ctrl_rb", 4'h0, 32'hF);
      wb_write(4'h4, 32'hFFFF_FFE7);
      reg_chk("cfg_rb", 4'h4, 32'h7);
      reg_chk("reg_c", 4'hC, 32'h0);

      // mode 0, 8 bit, MSB first
      wb_write(4'h0, 32'h1);
      spi_frame(32'hA5, 8, 8, 4'h1);
      wait_drain();
      reg_chk("status_a5", 4'h8, exp_status());

      // mode 3, 32 bit, LSB first
      wb_write(4'h4, 32'd31);
      wb_write(4'h0, 32'hF);
      spi_frame(32'h1234_5678, 32, 32, 4'hF);
      wait_drain();

      // overflow with a stalled consumer
      rdy_mode = 0;
      wb_write(4'h4, 32'd7);
      wb_write(4'h0, 32'h1);
      for (int i = 0; i < 5; i++) spi_frame(32'($urandom_range(0, 255)), 8, 8, 4'h1);
      wait_clk(4);
      reg_chk("status_ovf", 4'h8, exp_status());
      chk("held_valid", {31'b0, tvalid}, 32'h1);
      chk("held_head", tdata, exp_q[0]);
      wb_write(4'h8, 32'h1);
      m_ovf = 1'b0;
      reg_chk("status_clr", 4'h8, exp_status());
      rdy_mode = 2;
      wait_drain();

      // aborted partial word, then a full one
      spi_frame(32'hFF, 8, 5, 4'h1);
      spi_frame(32'h3C, 8, 8, 4'h1);
      wait_drain();

      // reset in the middle of a frame
      sclk = 1'b0; wait_clk(4);
      cs_n = 1'b0; wait_clk(4);
      spi_bits(32'hE7, 8, 3, 4'h1);
      rst_n = 1'b0;
      wait_clk(2);
      chk("midrst_tvalid", {31'b0, tvalid}, 32'h0);
      chk("midrst_tdata",  tdata, 32'h0);
      chk("midrst_ack",    {31'b0, ack}, 32'h0);
      cs_n = 1'b1; sclk = 1'b0;
      exp_q.delete(); m_ovf = 1'b0;
      wait_clk(1);
      rst_n = 1'b1;
      wait_clk(4);
      reg_chk("post_rst_ctrl",   4'h0, 32'h0);
      reg_chk("post_rst_cfg",    4'h4, 32'h0);
      reg_chk("post_rst_status", 4'h8, 32'h0);
      wb_write(4'h4, 32'd7);
      wb_write(4'h0, 32'h1);
      spi_frame(32'h81, 8, 8, 4'h1);
      wait_drain();

      // random modes, lengths and data with a random-ready consumer
      rdy_mode = 1;
      for (int i = 0; i < 24; i++) begin
         m  = {28'b0, 3'($urandom_range(0, 7)), 1'b1};
         wl = $urandom_range(1, 32);
         d  = $urandom;
         wb_write(4'h4, 32'(wl - 1));
         wb_write(4'h0, m);
         spi_frame(d, wl, wl, m[3:0]);
      end
      rdy_mode = 2;
      wait_drain();
      reg_chk("status_end", 4'h8, exp_status());

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/wfg_record_spi_top.md
WFG_RECORD_SPI_TOP -- requirements
Module: wfg_record_spi_top

Interface
REQ-001 Parameter BUSW, 32, Wishbone data/address width.
REQ-002 Parameter FIFO_DEPTH, 4, output word FIFO entries (power of two, >=2).
REQ-003 wb_clk_i  in  1  sole clock; all logic on rising edge.
REQ-004 wb_rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-005 wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe/cycle/write.
REQ-006 wbs_sel_i  in  4  byte select; ignored, full-word access only.
REQ-007 wbs_adr_i  in  BUSW  byte address; only bits [3:0] decoded.
REQ-008 wbs_dat_i  in  BUSW  write data.
REQ-009 wbs_ack_o  out  1  access acknowledge.
REQ-010 wbs_dat_o  out  BUSW  read data.
REQ-011 wfg_record_spi_sclk_i, wfg_record_spi_cs_ni, wfg_record_spi_sdi_i  in  1 each  asynchronous SPI inputs from an external transmitter.
REQ-012 wfg_axis_tready_i  in  1  downstream ready.
REQ-013 wfg_axis_tvalid_o  out  1  word valid.
REQ-014 wfg_axis_tdata_o  out  32  received word, right-aligned, upper bits zero.

Function
REQ-015 Registers: 0x0 CTRL {[0] en, [1] cpol, [2] cpha, [3] lsb_first}; 0x4 CFG {[4:0] wlen-1}; 0x8 STATUS {[0] ovf sticky, [8:4] fifo level} read-only except write-1-clear of ovf; 0xC reads 0.
REQ-016 Wishbone: wbs_ack_o pulses exactly one cycle, the cycle after stb&cyc sampled high with ack low; no back-to-back ack; write takes effect with ack.
REQ-017 SPI inputs pass through 2-flop synchronizers; sclk edges detected from synchronized stages; supported sclk <= wb_clk_i/4.
REQ-018 Sample edge: leading edge (idle->active per cpol) when cpha=0, trailing edge when cpha=1; sdi sampled from the same synchronized stage as the edge.
REQ-019 States IDLE, SHIFT: IDLE->SHIFT on synchronized cs_n falling while en=1; SHIFT->IDLE on cs_n rising or en cleared.
REQ-020 In SHIFT, each sample edge shifts one bit (MSB-first default, LSB-first if lsb_first) and increments 5-bit counter.
REQ-021 When counter equals wlen-1 on a sample edge, the assembled word (wlen bits) is pushed to FIFO the next cycle, counter returns 0, state stays SHIFT.
REQ-022 cs_n rising mid-word discards the partial word and zeroes counter; no push.
REQ-023 Push while FIFO full drops the new word, sets ovf; FIFO contents unchanged.
REQ-024 AXIS: tvalid high whenever FIFO non-empty; tdata = FIFO head; pop on tvalid&tready; tdata stable while tvalid&!tready.
REQ-025 Simultaneous push and pop on a full FIFO: pop succeeds, push accepted, no overflow.
REQ-026 Clearing en flushes nothing already in FIFO; CTRL/CFG writes while SHIFT take effect at next IDLE->SHIFT.
REQ-027 Configuration is shadowed at IDLE->SHIFT transition.

Reset
REQ-028 On wb_rst_ni low: all registers 0, state IDLE, counter 0, FIFO empty, synchronizers loaded with 1 for cs_n and cpol-independent 0 for sclk/sdi.
REQ-029 Outputs in reset: wbs_ack_o=0, wbs_dat_o=0, wfg_axis_tvalid_o=0, wfg_axis_tdata_o=0.
REQ-030 Reset asserted mid-word abandons the word; first frame after release requires a fresh cs_n falling edge.

Structure
REQ-031 Package wfg_record_spi_pkg holds register offsets, ctrl_t/cfg_t packed structs, and state enum.
REQ-032 Sub-module wfg_record_spi_wishbone_reg implements REQ-015/016 and exports ctrl/cfg, ovf-clear pulse; top holds synchronizers, FSM, FIFO.

Verification
REQ-033 Mode 0, wlen=8, MSB-first, send 0xA5 -> one AXIS word 0x000000A5, ovf=0.
REQ-034 Mode 3, wlen=32, LSB-first, send 0x12345678 bit-reversed on wire -> tdata 0x12345678.
REQ-035 tready=0, five 8-bit words -> four held in order, STATUS ovf=1 level=4; write 0x1 to 0x8 -> ovf=0.
REQ-036 cs_n rises after 5 of 8 bits, then full byte 0x3C -> only 0x3C emitted.
REQ-037 Reset asserted after 3 bits -> tvalid=0, registers read 0; next full frame 0x81 received correctly.
REQ-038 Wishbone read of 0x0 after writing 0xF -> data 0xF, ack high exactly one cycle.
